// File: rtl/uwasic_onboarding_emir_pkg.sv
// Shared constants for the SPI register block and PWM output controller.
// Register map, frame length and default PWM prescale.
package uwasic_onboarding_emir_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int NUM_REGS         = 5;
  localparam int FRAME_LEN        = 16;
  localparam int PRESCALE_DEFAULT = 13;

endpackage

// File: rtl/uwasic_onboarding_emir_spi_peripheral.sv
// Write-only SPI mode-0 register peripheral.
// Synchronizes SCLK/COPI/nCS, shifts 16-bit frames, commits valid writes.
module uwasic_onboarding_emir_spi_peripheral
  import uwasic_onboarding_emir_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        copi,
  input  logic        ncs,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty
);

  localparam logic [4:0] LEN = 5'(FRAME_LEN);

  logic [2:0]  sclk_q;
  logic [2:0]  ncs_q;
  logic [1:0]  copi_q;
  logic        sclk_rise;
  logic        ncs_rise;
  logic        ncs_fall;
  logic [4:0]  bit_cnt;
  logic        ovf;
  logic [15:0] shreg;
  logic        commit;
  logic [6:0]  addr;
  logic [7:0]  en_out_lo;
  logic [7:0]  en_out_hi;
  logic [7:0]  en_pwm_lo;
  logic [7:0]  en_pwm_hi;
  logic [7:0]  duty_q;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
  assign addr      = shreg[14:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      ncs_q  <= '0;
      copi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ncs_q  <= {ncs_q[1:0], ncs};
      copi_q <= {copi_q[0], copi};
    end
  end

  // ovf marks frames longer than 16 bits so they are dropped too
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      ovf     <= 1'b0;
      shreg   <= '0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (ncs_fall) begin
        bit_cnt <= '0;
        ovf     <= 1'b0;
        shreg   <= '0;
      end else if (!ncs_q[1] && sclk_rise) begin
        shreg <= {shreg[14:0], copi_q[1]};
        if (bit_cnt == LEN) ovf <= 1'b1;
        else bit_cnt <= bit_cnt + 5'd1;
      end
      if (ncs_rise)
        commit <= (bit_cnt == LEN) && !ovf && shreg[15]
                  && (addr < 7'(NUM_REGS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_lo <= '0;
      en_out_hi <= '0;
      en_pwm_lo <= '0;
      en_pwm_hi <= '0;
      duty_q    <= '0;
    end else if (commit) begin
      unique case (1'b1)
        addr == ADDR_EN_OUT_LO: en_out_lo <= shreg[7:0];
        addr == ADDR_EN_OUT_HI: en_out_hi <= shreg[7:0];
        addr == ADDR_EN_PWM_LO: en_pwm_lo <= shreg[7:0];
        addr == ADDR_EN_PWM_HI: en_pwm_hi <= shreg[7:0];
        addr == ADDR_DUTY:      duty_q    <= shreg[7:0];
        default: ;
      endcase
    end
  end

  assign en_out = {en_out_hi, en_out_lo};
  assign en_pwm = {en_pwm_hi, en_pwm_lo};
  assign duty   = duty_q;

endmodule

// File: rtl/uwasic_onboarding_emir.sv
// Tiny Tapeout top: SPI-configured 16-channel output / PWM controller.
// Outputs 7:0 on uo_out, 15:8 on uio_out (pads always driven).
module uwasic_onboarding_emir
  import uwasic_onboarding_emir_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [15:0]     en_out;
  logic [15:0]     en_pwm;
  logic [7:0]      duty;
  logic [PS_W-1:0] pre_cnt;
  logic [7:0]      pwm_cnt;
  logic            pwm;
  logic [15:0]     out_q;
  logic            unused_ok;

  uwasic_onboarding_emir_spi_peripheral u_spi (
    .clk    (clk),
    .rst    (rst),
    .sclk   (ui_in[0]),
    .copi   (ui_in[1]),
    .ncs    (ui_in[2]),
    .en_out (en_out),
    .en_pwm (en_pwm),
    .duty   (duty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (pre_cnt == PS_W'(PRESCALE - 1)) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      pre_cnt <= pre_cnt + PS_W'(1);
    end
  end

  // full-scale duty forces solid high instead of 255/256
  assign pwm = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else out_q <= en_out & (~en_pwm | {16{pwm}});
  end

  assign uo_out    = out_q[7:0];
  assign uio_out   = out_q[15:8];
  assign uio_oe    = 8'hFF;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_emir.sv
// Self-checking bench: directed SPI frames plus random frames
// compared against a register/PWM reference model.
module tb_uwasic_onboarding_emir;

  localparam int PRESCALE = 13;
  localparam int PERIOD   = 256 * PRESCALE;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       ena  = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs  = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [7:0] m_regs [5];

  assign ui_in = {5'b0, ncs, copi, sclk};

  uwasic_onboarding_emir dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs,
                           input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] w, input int nbits);
    ncs = 1'b0;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = w[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    ncs = 1'b1;
  endtask

  task automatic model_frame(input logic [31:0] w, input int nbits);
    if (nbits == 16 && w[15] && w[14:8] <= 7'd4)
      m_regs[w[10:8]] = w[7:0];
  endtask

  task automatic write(input logic [15:0] w);
    spi_xfer({16'h0, w}, 16);
    model_frame({16'h0, w}, 16);
    tick(8);
  endtask

  function automatic logic [15:0] model_out();
    int k;
    logic p;
    k = (n > 0) ? ((n - 1) / PRESCALE) % 256 : 0;
    p = (m_regs[4] == 8'hFF) ? 1'b1 : (k < int'(m_regs[4]));
    return {m_regs[1], m_regs[0]} & (~{m_regs[3], m_regs[2]} | {16{p}});
  endfunction

  task automatic wait_lvl(input logic v, input int maxc, output int c);
    c = 0;
    while (uo_out[0] !== v && c < maxc) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    int c, h, l, errs;
    logic [15:0] w;
    logic [6:0]  a;

    foreach (m_regs[i]) m_regs[i] = 8'h00;

    tick(5);
    check("rst_uo", {24'h0, uo_out}, 32'h00);
    check("rst_uio", {24'h0, uio_out}, 32'h00);
    check("rst_oe", {24'h0, uio_oe}, 32'hFF);
    rst = 1'b0;
    tick(4);

    spi_xfer(32'h80F0, 16);
    model_frame(32'h80F0, 16);
    c = 0;
    while (uo_out !== 8'hF0 && c < 5) begin
      @(negedge clk);
      c++;
    end
    check("static_lo", {24'h0, uo_out}, 32'hF0);
    tick(4);
    spi_xfer(32'h81CC, 16);
    model_frame(32'h81CC, 16);
    c = 0;
    while (uio_out !== 8'hCC && c < 5) begin
      @(negedge clk);
      c++;
    end
    check("static_hi", {24'h0, uio_out}, 32'hCC);
    tick(4);

    spi_xfer(32'hB0AA, 16);
    tick(8);
    check("rej_addr", {16'h0, uio_out, uo_out}, 32'hCCF0);
    spi_xfer(32'h0055, 16);
    tick(8);
    check("rej_read", {16'h0, uio_out, uo_out}, 32'hCCF0);
    spi_xfer(32'h800, 12);
    tick(8);
    check("rej_short", {16'h0, uio_out, uo_out}, 32'hCCF0);
    spi_xfer(32'h18055, 20);
    tick(8);
    check("rej_long", {16'h0, uio_out, uo_out}, 32'hCCF0);

    write(16'h8001);
    write(16'h8201);
    write(16'h8480);
    wait_lvl(1'b0, 2 * PERIOD, c);
    check("pwm_wait0", {31'h0, c < 2 * PERIOD}, 32'h1);
    wait_lvl(1'b1, 2 * PERIOD, c);
    check("pwm_wait1", {31'h0, c < 2 * PERIOD}, 32'h1);
    wait_lvl(1'b0, 2 * PERIOD, h);
    wait_lvl(1'b1, 2 * PERIOD, l);
    check_rng("pwm_high", h, PERIOD / 2 - 13, PERIOD / 2 + 13);
    check_rng("pwm_period", h + l, PERIOD - 1, PERIOD + 1);

    write(16'h8400);
    errs = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b0) errs++;
    end
    check("duty00_const", errs, 0);
    write(16'h84FF);
    errs = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b1) errs++;
    end
    check("dutyFF_const", errs, 0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(5, 127));
      else a = 7'($urandom_range(0, 4));
      w = {1'($urandom_range(0, 3) != 0), a, 8'($urandom)};
      spi_xfer({16'h0, w}, 16);
      model_frame({16'h0, w}, 16);
      tick(8 + $urandom_range(0, 40));
      check("rand", {16'h0, uio_out, uo_out}, {16'h0, model_out()});
    end

    ncs = 1'b0;
    tick(4);
    for (int i = 15; i >= 8; i--) begin
      copi = 1'(16'h8055 >> i);
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    rst = 1'b1;
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    tick(3);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      copi = 1'(16'h8055 >> i);
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    ncs = 1'b1;
    tick(8);
    check("midrst_nowr", {16'h0, uio_out, uo_out}, {16'h0, model_out()});
    check("midrst_zero", {16'h0, uio_out, uo_out}, 32'h0000);
    write(16'h8055);
    check("after_rst_wr", {24'h0, uo_out}, 32'h55);
    check("after_rst_oe", {24'h0, uio_oe}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uwasic_onboarding_emir.md
Name: uwasic_onboarding_emir

Overview:
Tiny Tapeout user block with two parts: an SPI-mode-0 write-only register peripheral and a 16-channel output/PWM controller. An external SPI master writes five 8-bit configuration registers. These registers set which of 16 outputs are enabled, which enabled outputs carry a PWM waveform, and the shared PWM duty cycle. Outputs 7:0 drive uo_out; outputs 15:8 drive the bidirectional pads, which are permanently configured as outputs.

Parameters:
PRESCALE, 13, number of clk cycles per PWM counter step. At 10 MHz this gives a PWM frequency of 10e6/(13*256) ≈ 3.0 kHz.
NUM_REGS, 5, number of writable registers (addresses 0x00–0x04).

Ports:
clk  input  1  system clock, 10 MHz nominal
rst  input  1  synchronous, active-high reset
ena  input  1  design-selected indicator; ignored
ui_in  input  8  bit0 = SCLK, bit1 = COPI, bit2 = nCS; bits 7:3 unused
uo_out  output  8  out[7:0]
uio_in  input  8  unused
uio_out  output  8  out[15:8]
uio_oe  output  8  constant 8'hFF

Behaviour:
- Reset (rst=1 at a clk edge):
  - All five registers clear to 0x00.
  - Synchronizers, bit counter and shift register clear.
  - PWM prescaler and counter clear to 0.
  - uo_out = 0x00 and uio_out = 0x00 from the first edge after reset.
  - uio_oe = 0xFF at all times.
- Input synchronization: SCLK, COPI and nCS each pass through a 2-flop synchronizer. Edge detection compares the 2nd and 3rd flop stages.
- SPI frame:
  - Mode 0 (CPOL=0, CPHA=0), MSB first, exactly 16 bits.
  - Bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
  - nCS falling edge clears the bit counter and the shift register.
  - While nCS is low, each synchronized SCLK rising edge shifts COPI in; the bit counter saturates at 16.
  - On the nCS rising edge, a write commits only if all of these hold: count == 16, R/W == 1, address <= 0x04. The commit happens in the cycle after the edge is detected.
  - Any other case (short frame, bit count above 16, R/W = 0, address > 4) is discarded with no register change. Reads return nothing; COPI is the only data line.
  - SCLK edges while nCS is high are ignored.
  - Reset asserted mid-frame aborts the frame.
- Registers:
  - 0x00 en_out[7:0], 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0], 0x03 en_pwm[15:8]
  - 0x04 duty[7:0]
- PWM:
  - The prescaler counts 0..PRESCALE-1. Each time it wraps, the 8-bit counter increments, wrapping 255 → 0.
  - pwm = (duty == 0xFF) ? 1 : (counter < duty).
  - duty = 0x00 gives constant 0; duty = 0xFF gives constant 1; duty = 0x80 gives 50% high time.
  - Period = 256*PRESCALE clk cycles.
  - A duty change takes effect immediately with no glitch filtering.
- Output per bit i:
  - out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0
  - Outputs are registered, adding one clk of latency after a register or pwm change.

Decomposition:
- Shared package: register address constants (ADDR_EN_OUT_LO = 0x00 through ADDR_DUTY = 0x04), frame length 16, default PRESCALE.
- Sub-module spi_peripheral: synchronizers, shift register and register file. It outputs en_out[15:0], en_pwm[15:0] and duty[7:0].
- The top level instantiates spi_peripheral and contains the PWM generator and output mux.

Test Plan:
- Reset: rst=1 for 5 cycles, nCS=1 → uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
- Static outputs: write 0x00←0xF0 and 0x01←0xCC (frames 0x80F0, 0x81CC) → uo_out = 0xF0 and uio_out = 0xCC within 5 clk after the nCS rise.
- Rejected frames, each leaving all outputs unchanged:
  - Write to address 0x30 (frame 0xB0AA).
  - Read frame 0x0055.
  - 12-bit frame with nCS raised early.
- PWM at 50%: write en_out lo = 0x01, en_pwm lo = 0x01, duty = 0x80 → uo_out[0] has period 3328 ±1 clk (≈3 kHz) and high time 1664 ±13 clk.
- PWM extremes: duty = 0x00 → uo_out[0] constant 0 over 2 periods; duty = 0xFF → uo_out[0] constant 1 over 2 periods.
- Mid-frame reset: assert rst after 8 bits of frame 0x8055, then release rst and complete the clock pulses → no write occurs; a following valid frame 0x8055 sets uo_out = 0x55.
